// File: rtl/decap_ctrl.sv
// Decapsulation controller: per-header-type rule table feeding slice/data offset,
// length and enable to the decapsulator, with packet and error accounting.
module decap_ctrl #(
  parameter int RULE_NUM = 16,
  parameter int LEN_MAX  = 31
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ctrl_en,
  input  logic        i_head_start,
  input  logic [3:0]  i_head_type,
  input  logic        i_pkt_tail,
  input  logic        i_cfg_wren,
  input  logic        i_cfg_rden,
  input  logic [3:0]  i_cfg_addr,
  input  logic [16:0] i_cfg_wdata,
  output logic [16:0] o_cfg_rdata,
  output logic        o_cfg_rvalid,
  output logic [3:0]  o_metaSliceOffset,
  output logic [5:0]  o_metaDataOffset,
  output logic [5:0]  o_decapLength,
  output logic        o_decapEn,
  output logic        o_busy,
  output logic [15:0] o_pkt_cnt,
  output logic [7:0]  o_err_cnt
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [4:0] RULE_LIM = 5'(RULE_NUM);
  localparam logic [5:0] LEN_LIM  = 6'(LEN_MAX);

  state_t      state_r;
  logic [16:0] table_r [RULE_NUM];
  logic [16:0] rule_s;
  logic        len_ok_s;
  logic        eff_en_s;
  logic        len_err_s;
  logic        miss_tail_s;
  logic        err_inc_s;
  logic        wr_ok_s;
  logic        rd_ok_s;
  logic [3:0]  hold_slice_r;
  logic [5:0]  hold_data_r;
  logic [5:0]  hold_len_r;
  logic        hold_en_r;
  logic [16:0] rdata_r;
  logic        rvalid_r;
  logic [15:0] pkt_cnt_r;
  logic [7:0]  err_cnt_r;

  // Rule lookup for the header type presented this cycle; unmapped types read as empty.
  always_comb begin
    rule_s = 17'd0;
    if ({1'b0, i_head_type} < RULE_LIM) begin
      rule_s = table_r[i_head_type];
    end else begin
      rule_s = 17'd0;
    end
  end

  assign len_ok_s    = (rule_s[5:0] <= LEN_LIM);
  assign eff_en_s    = rule_s[16] & i_ctrl_en & len_ok_s;
  assign len_err_s   = rule_s[16] & ~len_ok_s;
  assign miss_tail_s = (state_r == ACTIVE) & ~i_pkt_tail;
  // Length error and missing tail in one start count as a single error.
  assign err_inc_s   = i_head_start & (len_err_s | miss_tail_s);
  assign wr_ok_s     = i_cfg_wren & ({1'b0, i_cfg_addr} < RULE_LIM);
  assign rd_ok_s     = ({1'b0, i_cfg_addr} < RULE_LIM);

  // Start cycle is zero-latency from the table; otherwise the held values drive out.
  assign o_metaSliceOffset = i_head_start ? rule_s[15:12] : hold_slice_r;
  assign o_metaDataOffset  = i_head_start ? rule_s[11:6]  : hold_data_r;
  assign o_decapLength     = i_head_start ? rule_s[5:0]   : hold_len_r;
  assign o_decapEn         = i_head_start ? eff_en_s      : hold_en_r;
  assign o_busy            = (state_r == ACTIVE);
  assign o_cfg_rdata       = rdata_r;
  assign o_cfg_rvalid      = rvalid_r;
  assign o_pkt_cnt         = pkt_cnt_r;
  assign o_err_cnt         = err_cnt_r;

  // Rule table storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RULE_NUM; i++) begin
        table_r[i] <= 17'd0;
      end
    end else if (wr_ok_s) begin
      table_r[i_cfg_addr] <= i_cfg_wdata;
    end
  end

  // Registered config read; a same-address write in this cycle is not yet visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_r  <= 17'd0;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= i_cfg_rden;
      if (i_cfg_rden) begin
        rdata_r <= rd_ok_s ? table_r[i_cfg_addr] : 17'd0;
      end
    end
  end

  // Packet FSM and the hold registers latched on every start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      hold_slice_r <= 4'd0;
      hold_data_r  <= 6'd0;
      hold_len_r   <= 6'd0;
      hold_en_r    <= 1'b0;
    end else begin
      if (i_head_start) begin
        hold_slice_r <= rule_s[15:12];
        hold_data_r  <= rule_s[11:6];
        hold_len_r   <= rule_s[5:0];
        hold_en_r    <= eff_en_s;
      end
      case (state_r)
        IDLE: begin
          if (i_head_start) begin
            state_r <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (!i_head_start && i_pkt_tail) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Packet counter wraps; error counter saturates.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_cnt_r <= 16'd0;
      err_cnt_r <= 8'd0;
    end else begin
      if (i_head_start && eff_en_s) begin
        pkt_cnt_r <= pkt_cnt_r + 16'd1;
      end
      if (err_inc_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

endmodule
